// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external combinational ALU: holds an 8-entry register file,
// registers one command's operands, captures the ALU result and offers it on a result handshake.
module alu_issue_ctrl #(
  parameter int word_size = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [2:0]           cmd_rs,
  input  logic [2:0]           cmd_rt,
  input  logic [2:0]           cmd_rd,
  input  logic                 cmd_wr,
  input  logic                 ld_en,
  input  logic [2:0]           ld_addr,
  input  logic [word_size-1:0] ld_data,
  output logic [word_size-1:0] alu_a,
  output logic [word_size-1:0] alu_b,
  output logic [2:0]           alu_op,
  input  logic [word_size-1:0] alu_result,
  input  logic                 alu_zero,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [word_size-1:0] res_data,
  output logic                 res_zero,
  output logic [2:0]           res_rd
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t               state, state_next;
  logic [word_size-1:0] regs [8];
  logic [2:0]           rd_p0;
  logic                 wr_p0;
  logic                 accept;
  logic                 writeback;

  assign accept    = (state == IDLE) && cmd_valid;
  assign writeback = (state == EXEC) && wr_p0 && (rd_p0 != 3'd0);
  assign cmd_ready = (state == IDLE);
  assign res_valid = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Loads are only legal in IDLE and writeback only happens in EXEC, so the two
  // write sources never collide. Entry 0 is never written, so it always reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if ((state == IDLE) && ld_en && (ld_addr != 3'd0)) begin
      regs[ld_addr] <= ld_data;
    end else if (writeback) begin
      regs[rd_p0] <= alu_result;
    end
  end

  // Stage p0: operand capture at command acceptance (reads pre-load register values)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      rd_p0  <= '0;
      wr_p0  <= 1'b0;
    end else if (accept) begin
      alu_a  <= regs[cmd_rs];
      alu_b  <= regs[cmd_rt];
      alu_op <= cmd_op;
      rd_p0  <= cmd_rd;
      wr_p0  <= cmd_wr;
    end
  end

  // Stage p1: result capture at the end of EXEC; held unchanged through RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data <= '0;
      res_zero <= 1'b0;
      res_rd   <= '0;
    end else if (state == EXEC) begin
      res_data <= alu_result;
      res_zero <= alu_zero;
      res_rd   <= rd_p0;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a small behavioural ALU on its operand outputs.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [2:0]  cmd_op, cmd_rs, cmd_rt, cmd_rd;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_zero;
  logic        res_valid, res_ready, res_zero;
  logic [31:0] res_data;
  logic [2:0]  res_rd;

  typedef struct {
    logic [31:0] data;
    logic        zero;
    logic [2:0]  rd;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_issue_ctrl #(.word_size(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_wr(cmd_wr),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_rd(res_rd)
  );

  always #5 clk = ~clk;

  // External ALU: 0 AND, 1 OR, 2 ADD, 3 SUB, 7 signed set-less-than
  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'd0: alu_result = alu_a & alu_b;
      3'd1: alu_result = alu_a | alu_b;
      3'd2: alu_result = alu_a + alu_b;
      3'd3: alu_result = alu_a - alu_b;
      3'd7: alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got data %h rd %0d, required no result", res_data, res_rd);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("res_data", res_data, e.data);
        check("res_zero", {31'd0, res_zero}, {31'd0, e.zero});
        check("res_rd", {29'd0, res_rd}, {29'd0, e.rd});
      end
    end
  end

  task automatic do_load(input logic [2:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, rs, rt, rd, input logic wr,
                       input logic push, input logic [31:0] d, input logic z);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_ready_timeout: got 0, required 1");
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_wr = wr;
    if (push) begin
      exp_t e;
      e.data = d; e.zero = z; e.rd = rd;
      q.push_back(e);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(q.size() == 0 && cmd_ready) && n < 20);
    if (!(q.size() == 0 && cmd_ready)) begin
      n_cmp++; n_bad++;
      $display("FAIL result_timeout: pending %0d, required 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 0; cmd_op = 0; cmd_rs = 0; cmd_rt = 0; cmd_rd = 0; cmd_wr = 0;
    ld_en = 0; ld_addr = 0; ld_data = 0; res_ready = 1'b1;
    #2;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // add with writeback, latency, then read back the written register
    do_load(3'd1, 32'd5);
    do_load(3'd2, 32'd7);
    issue(3'd2, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 32'd12, 1'b0);
    check("exec_res_valid", {31'd0, res_valid}, 32'd0);
    check("exec_alu_a", alu_a, 32'd5);
    check("exec_alu_b", alu_b, 32'd7);
    check("exec_alu_op", {29'd0, alu_op}, 32'd2);
    @(posedge clk); #1;
    check("resp_res_valid", {31'd0, res_valid}, 32'd1);
    check("resp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    wait_done();
    issue(3'd0, 3'd3, 3'd3, 3'd5, 1'b0, 1'b1, 32'd12, 1'b0);
    wait_done();

    // equal operands give zero
    do_load(3'd1, 32'h0000_00A5);
    do_load(3'd2, 32'h0000_00A5);
    issue(3'd3, 3'd1, 3'd2, 3'd6, 1'b0, 1'b1, 32'd0, 1'b1);
    wait_done();

    // signed compare in both directions
    do_load(3'd1, 32'hFFFF_FFFF);
    do_load(3'd2, 32'd1);
    issue(3'd7, 3'd1, 3'd2, 3'd1, 1'b0, 1'b1, 32'd1, 1'b0);
    wait_done();
    issue(3'd7, 3'd2, 3'd1, 3'd1, 1'b0, 1'b1, 32'd0, 1'b1);
    wait_done();

    // register 0 ignores writeback and direct loads
    do_load(3'd1, 32'd3);
    do_load(3'd2, 32'd4);
    issue(3'd2, 3'd1, 3'd2, 3'd0, 1'b1, 1'b1, 32'd7, 1'b0);
    wait_done();
    issue(3'd0, 3'd0, 3'd0, 3'd2, 1'b0, 1'b1, 32'd0, 1'b1);
    wait_done();
    do_load(3'd0, 32'hDEAD_BEEF);
    issue(3'd0, 3'd0, 3'd0, 3'd2, 1'b0, 1'b1, 32'd0, 1'b1);
    wait_done();

    // load and command in the same cycle: command sees the old value
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 32'd9;
    issue(3'd2, 3'd1, 3'd2, 3'd0, 1'b0, 1'b1, 32'd7, 1'b0);
    ld_en = 1'b0;
    wait_done();
    issue(3'd2, 3'd1, 3'd2, 3'd0, 1'b0, 1'b1, 32'd13, 1'b0);
    wait_done();

    // back-pressure: result held, commands and loads ignored
    res_ready = 1'b0;
    issue(3'd2, 3'd1, 3'd2, 3'd7, 1'b1, 1'b1, 32'd13, 1'b0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_rs = 3'd1; cmd_rt = 3'd1; cmd_rd = 3'd6; cmd_wr = 1'b1;
    ld_en = 1'b1; ld_addr = 3'd2; ld_data = 32'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_res_valid", {31'd0, res_valid}, 32'd1);
      check("hold_res_data", res_data, 32'd13);
      check("hold_res_rd", {29'd0, res_rd}, 32'd7);
      check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; ld_en = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    check("release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("release_res_valid", {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;
    check("no_extra_result", {31'd0, res_valid}, 32'd0);
    issue(3'd0, 3'd2, 3'd2, 3'd1, 1'b0, 1'b1, 32'd4, 1'b0);
    wait_done();
    issue(3'd0, 3'd6, 3'd6, 3'd1, 1'b0, 1'b1, 32'd0, 1'b1);
    wait_done();
    issue(3'd0, 3'd7, 3'd7, 3'd1, 1'b0, 1'b1, 32'd13, 1'b0);
    wait_done();

    // reset during EXEC aborts the writeback and the result
    issue(3'd2, 3'd1, 3'd2, 3'd4, 1'b1, 1'b0, 32'd0, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("abort_res_valid", {31'd0, res_valid}, 32'd0);
    check("abort_alu_a", alu_a, 32'd0);
    check("abort_alu_b", alu_b, 32'd0);
    check("abort_alu_op", {29'd0, alu_op}, 32'd0);
    check("abort_res_data", res_data, 32'd0);
    check("abort_res_rd", {29'd0, res_rd}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_valid", {31'd0, res_valid}, 32'd0);
    end
    @(posedge clk); #1;
    issue(3'd0, 3'd4, 3'd4, 3'd2, 1'b0, 1'b1, 32'd0, 1'b1);
    wait_done();

    check("scoreboard_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have parameter word_size, default 32, giving the data path width.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have ports cmd_valid input 1, cmd_ready output 1, cmd_op input 3, cmd_rs input 3, cmd_rt input 3, cmd_rd input 3, cmd_wr input 1, forming the command handshake (operation, source registers, destination, writeback enable).
REQ-005 The block SHALL have ports ld_en input 1, ld_addr input 3, ld_data input word_size, a direct register-load port.
REQ-006 The block SHALL have ports alu_a output word_size, alu_b output word_size, alu_op output 3, driving the combinational ALU operand/opcode inputs (R2, R3, ALUOp).
REQ-007 The block SHALL have ports alu_result input word_size, alu_zero input 1, receiving the ALU result and zero flag (R1, Zero).
REQ-008 The block SHALL have ports res_valid output 1, res_ready input 1, res_data output word_size, res_zero output 1, res_rd output 3, forming the result handshake.

Function
REQ-009 The block SHALL hold an 8 x word_size register file; register 0 SHALL always read 0 and ignore all writes.
REQ-010 The FSM SHALL have states IDLE, EXEC, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-011 IDLE -> EXEC on a clk edge with cmd_valid=1; at that edge regfile[cmd_rs] SHALL be latched onto alu_a, regfile[cmd_rt] onto alu_b, cmd_op onto alu_op, and cmd_rd, cmd_wr latched internally.
REQ-012 EXEC SHALL last exactly one cycle; at its ending edge alu_result and alu_zero SHALL be captured into res_data and res_zero, res_rd set to latched rd, and the FSM SHALL enter RESP.
REQ-013 At that same edge, if latched cmd_wr=1 and rd!=0, regfile[rd] SHALL be written with alu_result; the new value is readable by a command accepted at or after the next edge.
REQ-014 res_valid SHALL be 1 exactly in RESP; res_data, res_zero, res_rd SHALL stay stable while res_valid=1 and res_ready=0.
REQ-015 RESP -> IDLE on a clk edge with res_ready=1; cmd_ready SHALL rise in the following cycle (no same-cycle command acceptance on result completion).
REQ-016 Latency: command accepted at edge N -> res_valid=1 from cycle after edge N+1; minimum issue interval 3 cycles.
REQ-017 alu_a, alu_b, alu_op SHALL be registered and hold their last values outside EXEC.
REQ-018 ld_en SHALL write ld_data to regfile[ld_addr] only in IDLE; ignored in EXEC/RESP and when ld_addr=0.
REQ-019 If ld_en=1 and cmd_valid=1 in the same IDLE cycle, the load SHALL complete and the command SHALL read register values from before the load.
REQ-020 cmd inputs SHALL be ignored outside IDLE; no command buffering.
REQ-021 Arithmetic and flags are produced solely by the external ALU; the block SHALL not modify alu_result bits or alu_zero.

Reset
REQ-022 While rst=1, the FSM SHALL be IDLE and cmd_ready=1, res_valid=0, res_data=0, res_zero=0, res_rd=0, alu_a=0, alu_b=0, alu_op=0, and all registers 0, independent of clk.
REQ-023 rst asserted in EXEC or RESP SHALL abort the operation with no register writeback and no res_valid pulse after release.

Verification
REQ-024 Load r1=5, r2=7; command op=2 rs=1 rt=2 rd=3 wr=1, res_ready=1 -> res_data=12, res_zero=0, res_rd=3 two cycles after acceptance; subsequent op=0 rs=3 returns 12.
REQ-025 Load r1=r2=0x0000_00A5; op=3 rs=1 rt=2 -> res_data=0, res_zero=1.
REQ-026 Load r1=0xFFFF_FFFF, r2=1; op=7 rs=1 rt=2 -> res_data=1 (signed compare); rs=2 rt=1 -> res_data=0, res_zero=1.
REQ-027 Command op=2 rs=1 rt=2 rd=0 wr=1 with r1=3, r2=4 -> res_data=7, then op=0 rs=0 returns 0; ld_en with ld_addr=0, ld_data=0xDEAD_BEEF -> r0 still reads 0.
REQ-028 Hold res_ready=0 for 5 cycles in RESP -> res_valid, res_data, res_rd constant, cmd_ready=0, cmd_valid ignored; release -> IDLE next cycle.
REQ-029 Assert rst during EXEC of op=2 rd=4 wr=1 -> all outputs 0, cmd_ready=1, r4 reads 0 afterwards.
